// File: rtl/sleep_if.sv
// Signal bundle between the vital energy system side and sleep_cycle_controller.
// master drives the energy/time-base inputs, slave is the controller.
interface sleep_if;
  logic       tick;
  logic [1:0] vital_energy_level;
  logic       vital_energy_zero;
  logic       wake_stimulus;
  logic [1:0] sleep_state;
  logic       asleep;
  logic       exhausted;

  modport master (
    output tick, vital_energy_level, vital_energy_zero, wake_stimulus,
    input  sleep_state, asleep, exhausted
  );

  modport slave (
    input  tick, vital_energy_level, vital_energy_zero, wake_stimulus,
    output sleep_state, asleep, exhausted
  );
endinterface

// File: rtl/sleep_cycle_controller.sv
// Sleep/wake FSM driven by vital energy level; turns energy depletion into drowsiness/sleep.
// Optional: define SLEEP_WAKE_STIMULUS_EN to allow stimulus-driven wake from ASLEEP.
module sleep_cycle_controller #(
  parameter int unsigned DROWSY_HOLD = 16,
  parameter int unsigned MIN_SLEEP   = 64,
  parameter int unsigned WAKE_HOLD   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  sleep_if.slave   bus
);

  localparam logic [1:0] ST_AWAKE  = 2'd0;
  localparam logic [1:0] ST_DROWSY = 2'd1;
  localparam logic [1:0] ST_ASLEEP = 2'd2;
  localparam logic [1:0] ST_WAKING = 2'd3;

  localparam logic [7:0] DROWSY_LAST   = 8'(DROWSY_HOLD - 1);
  localparam logic [7:0] WAKE_LAST     = 8'(WAKE_HOLD - 1);
  localparam logic [7:0] MIN_SLEEP_CNT = 8'(MIN_SLEEP);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic [7:0] cnt_inc;
  logic       asleep_q;
  logic       exhausted_q;
  logic       collapse;
  logic       level_zero;
  logic       level_full;
  logic       wake_ok;
  logic       stim_wake;

  assign level_zero = (bus.vital_energy_level == 2'd0);
  assign level_full = (bus.vital_energy_level == 2'd3);
  // Saturation keeps wake eligibility permanent once MIN_SLEEP is reached.
  assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign wake_ok    = (cnt >= MIN_SLEEP_CNT);

`ifdef SLEEP_WAKE_STIMULUS_EN
  assign stim_wake = bus.wake_stimulus && !level_zero;
`else
  assign stim_wake = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    collapse   = 1'b0;

    case (state)
      ST_AWAKE: begin
        if (bus.vital_energy_zero) begin
          state_next = ST_ASLEEP;
          collapse   = 1'b1;
        end else if (!level_zero) begin
          cnt_next = '0;
        end else if (bus.tick) begin
          if (cnt == DROWSY_LAST) state_next = ST_DROWSY;
          else                    cnt_next   = cnt_inc;
        end
      end

      ST_DROWSY: begin
        if (bus.vital_energy_zero) begin
          state_next = ST_ASLEEP;
          collapse   = 1'b1;
        end else if (!level_zero) begin
          state_next = ST_AWAKE;
        end else if (bus.wake_stimulus) begin
          cnt_next = '0;
        end else if (bus.tick) begin
          if (cnt == DROWSY_LAST) state_next = ST_ASLEEP;
          else                    cnt_next   = cnt_inc;
        end
      end

      ST_ASLEEP: begin
        // Energy-zero is deliberately ignored here: the organism is already asleep.
        if (wake_ok && (level_full || stim_wake)) begin
          state_next = ST_WAKING;
        end else if (bus.tick) begin
          cnt_next = cnt_inc;
        end
      end

      ST_WAKING: begin
        if (bus.vital_energy_zero) begin
          state_next = ST_ASLEEP;
          collapse   = 1'b1;
        end else if (bus.tick) begin
          if (cnt == WAKE_LAST) state_next = ST_AWAKE;
          else                  cnt_next   = cnt_inc;
        end
      end
    endcase

    if (state_next != state) cnt_next = '0;
  end

  // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_AWAKE;
      cnt         <= '0;
      asleep_q    <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      asleep_q    <= (state_next == ST_ASLEEP);
      exhausted_q <= collapse;
    end
  end

  assign bus.sleep_state = state;
  assign bus.asleep      = asleep_q;
  assign bus.exhausted   = exhausted_q;

endmodule

// File: tb/tb_sleep_cycle_controller.sv
// Directed table-driven bench for sleep_cycle_controller with default parameters,
// plus hand sequences for stimulus wake and asynchronous reset.
module tb_sleep_cycle_controller;

  typedef struct {
    string      name;
    logic       rst;
    logic       tick;
    logic [1:0] level;
    logic       zero;
    logic       stim;
    int         cycles;
    logic       every;
    logic [1:0] st;
    logic       slp;
    logic       exh;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  sleep_if bus ();

  sleep_cycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic [1:0] st, input logic slp, input logic exh);
    check({name, ".state"},     8'(bus.sleep_state), 8'(st));
    check({name, ".asleep"},    8'(bus.asleep),      8'(slp));
    check({name, ".exhausted"}, 8'(bus.exhausted),   8'(exh));
  endtask

  task automatic add(input string name, input logic rst, input logic tick, input logic [1:0] level,
                     input logic zero, input logic stim, input int cycles, input logic every,
                     input logic [1:0] st, input logic slp, input logic exh);
    vec_t v;
    v.name = name; v.rst = rst; v.tick = tick; v.level = level; v.zero = zero; v.stim = stim;
    v.cycles = cycles; v.every = every; v.st = st; v.slp = slp; v.exh = exh;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic tick, input logic [1:0] level, input logic zero, input logic stim);
    bus.tick               = tick;
    bus.vital_energy_level = level;
    bus.vital_energy_zero  = zero;
    bus.wake_stimulus      = stim;
  endtask

  initial begin
    //  name            rst tick lvl  zero stim cyc every  st   slp  exh
    add("awake_lvl2",    0, 1, 2'd2, 0, 0, 100, 1, 2'd0, 0, 0);
    add("lvl0_count",    0, 1, 2'd0, 0, 0,  15, 1, 2'd0, 0, 0);
    add("to_drowsy",     0, 1, 2'd0, 0, 0,   1, 0, 2'd1, 0, 0);
    add("drowsy_count",  0, 1, 2'd0, 0, 0,  15, 1, 2'd1, 0, 0);
    add("to_asleep",     0, 1, 2'd0, 0, 0,   1, 0, 2'd2, 1, 0);
    add("asleep_zero",   0, 0, 2'd0, 1, 0,  10, 1, 2'd2, 1, 0);
    add("asleep_notick", 0, 0, 2'd3, 0, 0,  50, 1, 2'd2, 1, 0);
    add("min_sleep",     0, 1, 2'd3, 0, 0,  64, 1, 2'd2, 1, 0);
    add("to_waking",     0, 1, 2'd3, 0, 0,   1, 0, 2'd3, 0, 0);
    add("waking_count",  0, 1, 2'd3, 0, 0,   3, 1, 2'd3, 0, 0);
    add("waking_done",   0, 1, 2'd3, 0, 0,   1, 0, 2'd0, 0, 0);
    add("collapse",      0, 1, 2'd2, 1, 0,   1, 0, 2'd2, 1, 1);
    add("collapse_hold", 0, 1, 2'd2, 1, 0,   2, 1, 2'd2, 1, 0);
    add("asleep_lvl2",   0, 1, 2'd2, 0, 0,  10, 1, 2'd2, 1, 0);
    add("saturate",      0, 1, 2'd0, 0, 0, 300, 1, 2'd2, 1, 0);
    add("sat_wake",      0, 1, 2'd3, 0, 0,   1, 0, 2'd3, 0, 0);
    add("waking_coll",   0, 0, 2'd3, 1, 0,   1, 0, 2'd2, 1, 1);
    add("waking_coll2",  0, 0, 2'd0, 0, 0,   1, 0, 2'd2, 1, 0);
    add("reset_a",       1, 0, 2'd0, 0, 0,   2, 1, 2'd0, 0, 0);
    add("drowsy_b",      0, 1, 2'd0, 0, 0,  16, 0, 2'd1, 0, 0);
    add("drowsy_exit",   0, 0, 2'd1, 0, 0,   1, 0, 2'd0, 0, 0);
    add("drowsy_b2",     0, 1, 2'd0, 0, 0,  16, 0, 2'd1, 0, 0);
    add("drowsy_coll",   0, 0, 2'd0, 1, 0,   1, 0, 2'd2, 1, 1);
    add("reset_b",       1, 1, 2'd0, 0, 0,   2, 1, 2'd0, 0, 0);
    add("drowsy_c",      0, 1, 2'd0, 0, 0,  16, 0, 2'd1, 0, 0);
    add("drowsy_cnt10",  0, 1, 2'd0, 0, 0,  10, 1, 2'd1, 0, 0);
    add("drowsy_stim",   0, 1, 2'd0, 0, 1,   1, 0, 2'd1, 0, 0);
    add("drowsy_after",  0, 1, 2'd0, 0, 0,  15, 1, 2'd1, 0, 0);
    add("drowsy_sleep",  0, 1, 2'd0, 0, 0,   1, 0, 2'd2, 1, 0);

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = !vecs[i].rst;
      drive(vecs[i].tick, vecs[i].level, vecs[i].zero, vecs[i].stim);
      for (int c = 0; c < vecs[i].cycles; c++) begin
        @(posedge clk);
        #1;
        if (vecs[i].every || c == vecs[i].cycles - 1)
          check_outs(vecs[i].name, vecs[i].st, vecs[i].slp, vecs[i].exh);
      end
    end

    // Fresh ASLEEP, level 1: stimulus at tick 30 is too early, at tick 70 it is eligible.
    for (int i = 1; i <= 70; i++) begin
      drive(1'b1, 2'd1, 1'b0, (i == 30 || i == 70));
      @(posedge clk);
      #1;
      if (i < 70) begin
        check_outs("stim_early", 2'd2, 1'b1, 1'b0);
      end else begin
`ifdef SLEEP_WAKE_STIMULUS_EN
        check_outs("stim_wake", 2'd3, 1'b0, 1'b0);
`else
        check_outs("stim_ignored", 2'd2, 1'b1, 1'b0);
`endif
      end
    end

    // Asynchronous reset mid-count in DROWSY, with tick low, takes effect before the next edge.
    rst_n = 1'b0;
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_outs("pre_async_rst", 2'd1, 1'b0, 1'b0);
    bus.tick = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outs("async_rst_hold", 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sleep_cycle_controller.md
# sleep_cycle_controller

Sleep/wake state machine directly downstream of the vital energy system in `src/sleep/`. It consumes the 2-bit vital energy level and the zero flag, and decides when the organism becomes drowsy, falls asleep, and wakes. Its state outputs feed action selection and the neurotransmitter regulators. It is the only block that turns energy depletion into behaviour.

## Interface
- `DROWSY_HOLD`, 16: ticks with energy level 0 needed to enter DROWSY, and ticks in DROWSY before falling asleep (1..255).
- `MIN_SLEEP`, 64: minimum ticks in ASLEEP before any wake is allowed (1..255).
- `WAKE_HOLD`, 4: ticks spent in WAKING before AWAKE (1..255).
- `clk` input 1: system clock. One clock; all state on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `tick` input 1: time-base enable. Counters advance only on cycles where `tick`=1.
- `vital_energy_level` input 2: energy bits [7:6] from the vital energy system.
- `vital_energy_zero` input 1: energy equals 0.
- `wake_stimulus` input 1: strong external stimulus (noise, touch).
- `sleep_state` output 2: AWAKE=0, DROWSY=1, ASLEEP=2, WAKING=3.
- `asleep` output 1: high when `sleep_state`=ASLEEP.
- `exhausted` output 1: one-cycle pulse on a forced collapse into ASLEEP.

## Operation
- One 8-bit saturating tick counter `cnt`. It increments on `tick` and saturates at 255. It is cleared to 0 on every state change.
- Collapse has highest priority in every state except ASLEEP:
  - Condition: `vital_energy_zero`=1 on any cycle, whether or not `tick` is high.
  - Action: next state ASLEEP, `cnt` cleared, `exhausted`=1 for the following cycle.
  - The pulse is registered and lasts exactly one cycle even if zero persists, because the state is then ASLEEP.
- AWAKE:
  - If `vital_energy_level`≠0, `cnt` is held at 0.
  - If level=0 and `tick`, `cnt` increments.
  - When `cnt`=DROWSY_HOLD−1 and `tick` with level=0, go to DROWSY.
- DROWSY:
  - Level≠0 → AWAKE. No tick needed.
  - `wake_stimulus`=1 → `cnt` cleared; stay in DROWSY.
  - Otherwise, when `cnt`=DROWSY_HOLD−1 and `tick` → ASLEEP.
- ASLEEP:
  - `cnt` counts ticks.
  - Wake is allowed only once `cnt`≥MIN_SLEEP.
  - Once allowed, level=3 → WAKING.
  - Early wake via stimulus is described under Configuration.
  - `vital_energy_zero` is ignored here.
- WAKING:
  - When `cnt`=WAKE_HOLD−1 and `tick` → AWAKE.
  - Collapse rule applies.
- Priority within a cycle, highest first: collapse, level-driven exit, stimulus, counter expiry.

## Timing
- Reset values: `sleep_state`=AWAKE (0), `cnt`=0, `asleep`=0, `exhausted`=0.
- Asynchronous reset mid-operation forces AWAKE immediately, regardless of `tick`.
- All outputs are registered.
- Latency: a state change is visible 1 cycle after the qualifying input or tick edge.
- `asleep` and `sleep_state` change in the same cycle as each other.
- `exhausted` is asserted in the same cycle that `sleep_state` first reads ASLEEP.
- Counter saturation at 255 never wraps. This keeps ASLEEP wake eligibility permanent after MIN_SLEEP.
- Inputs are synchronous to `clk`; no synchronisers inside.

## Configuration
- Macro: `SLEEP_WAKE_STIMULUS_EN`.
- Defined: in ASLEEP with `cnt`≥MIN_SLEEP, `wake_stimulus`=1 and level≥1 → WAKING.
- Not defined: `wake_stimulus` is ignored in ASLEEP; only level=3 wakes. DROWSY behaviour is identical in both builds.

## Test plan
Default parameters, `tick` every cycle unless stated.
- Reset release, level=2 for 100 cycles → state stays 0, `exhausted` never 1.
- Level=0 in AWAKE:
  - State=1 after 16 ticks.
  - State=2 after 16 more ticks.
  - `asleep`=1, `exhausted` stays 0.
- Collapse: in AWAKE with level=2, pulse `vital_energy_zero`=1 for 3 cycles → next cycle state=2, `exhausted`=1 for exactly one cycle.
- In ASLEEP, level=3 from entry:
  - WAKING only after 64 ticks.
  - AWAKE 4 ticks later.
  - With `tick`=0 throughout, state stays 2.
- `SLEEP_WAKE_STIMULUS_EN` in ASLEEP, level=1, `wake_stimulus`=1 at tick 30 and tick 70:
  - Defined: the tick-30 stimulus is ignored, the tick-70 stimulus → WAKING.
  - Undefined: state remains 2.
- In DROWSY at `cnt`=10, `wake_stimulus` pulse → counter cleared; ASLEEP reached 16 ticks after the pulse. Assert `rst_n` mid-count → state 0 immediately.
